// File: rtl/atm_disp_pkg.sv
// Shared constants and types for the ATM display datapath.
// Used by the binary-to-BCD converter and the seven-segment display driver.
package atm_disp_pkg;

   localparam int          BCD_DIGITS = 8;
   localparam int          BIN_W      = 27;
   localparam logic [26:0] BCD_MAX    = 27'd99_999_999;
   localparam logic [31:0] BCD_SAT    = 32'h9999_9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell.
// Adds 3 to a BCD nibble of 5 or more so that the next left shift carries correctly.
module bcd_add3 (
   input  logic [3:0] din,
   input  logic [3:0] dout_unused_n,
   output logic [3:0] dout
);

   logic [3:0] unused_n;
   assign unused_n = dout_unused_n;

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/atm_bcd_converter.sv
// Sequential binary-to-packed-BCD converter that feeds the display driver.
// Converts one bit per clock, saturates above the maximum and builds a leading-zero mask.
module atm_bcd_converter #(
   parameter int BIN_W  = atm_disp_pkg::BIN_W,
   parameter int DIGITS = atm_disp_pkg::BCD_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow,
   output logic [DIGITS-1:0]     lead_mask
);

   import atm_disp_pkg::*;

   localparam int CNT_W = $clog2(BIN_W + 1);

   bcd_state_t          state;
   logic [4*DIGITS-1:0] scratch;
   logic [4*DIGITS-1:0] adj;
   logic [4*DIGITS-1:0] scratch_nxt;
   logic [4*DIGITS-1:0] load_val;
   logic [BIN_W-1:0]    shreg;
   logic [CNT_W-1:0]    count;
   logic                ovf;
   logic [DIGITS-1:0]   mask_nxt;

   // All nibble corrections happen in parallel, then the whole word shifts.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din           (scratch[4*g +: 4]),
         .dout_unused_n (4'h0),
         .dout          (adj[4*g +: 4])
      );
   end

   assign scratch_nxt = {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
   assign load_val    = ovf ? {DIGITS{4'h9}} : scratch_nxt;

   // A digit is significant if it or any more-significant digit is nonzero.
   always_comb begin
      mask_nxt = '0;
      mask_nxt[DIGITS-1] = |load_val[4*DIGITS-1 -: 4];
      for (int i = DIGITS - 2; i >= 0; i--)
         mask_nxt[i] = mask_nxt[i+1] | (|load_val[4*i +: 4]);
      mask_nxt[0] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd_out   <= '0;
         overflow  <= 1'b0;
         lead_mask <= {{(DIGITS-1){1'b0}}, 1'b1};
         scratch   <= '0;
         shreg     <= '0;
         count     <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= bin_in;
                  scratch <= '0;
                  count   <= '0;
                  ovf     <= (bin_in > BIN_W'(BCD_MAX));
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= scratch_nxt;
               shreg   <= {shreg[BIN_W-2:0], 1'b0};
               count   <= count + CNT_W'(1);
               // Outputs only change here, so the display never sees partial results.
               if (count == CNT_W'(BIN_W - 1)) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  bcd_out   <= load_val;
                  lead_mask <= mask_nxt;
                  overflow  <= ovf;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_bcd_converter.sv
// Directed bench for atm_bcd_converter: latency, saturation, mask, start filtering, reset abort.
module tb_atm_bcd_converter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [26:0] bin_in = '0;
   logic        busy, done, overflow;
   logic [31:0] bcd_out;
   logic [7:0]  lead_mask;

   int n_chk  = 0;
   int n_pass = 0;

   atm_bcd_converter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bin_in    (bin_in),
      .busy      (busy),
      .done      (done),
      .bcd_out   (bcd_out),
      .overflow  (overflow),
      .lead_mask (lead_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a conversion, then watch 32 cycles for busy length, done position and result.
   task automatic conv(input string tag, input logic [26:0] v, input logic [31:0] exp_bcd,
                       input logic [7:0] exp_mask, input logic exp_ovf);
      int nb, nd, dat;
      start = 1'b1; bin_in = v;
      tick();
      start = 1'b0; bin_in = 27'($urandom);
      nb = 0; nd = 0; dat = -1;
      for (int i = 0; i < 32; i++) begin
         if (busy) nb++;
         if (done) begin nd++; if (dat < 0) dat = i; end
         tick();
      end
      chk({tag, "_busy_cycles"}, 64'(nb), 64'd27);
      chk({tag, "_done_pos"},    64'(dat), 64'd27);
      chk({tag, "_done_count"},  64'(nd), 64'd1);
      chk({tag, "_bcd"},         64'(bcd_out), 64'(exp_bcd));
      chk({tag, "_mask"},        64'(lead_mask), 64'(exp_mask));
      chk({tag, "_ovf"},         64'(overflow), 64'(exp_ovf));
   endtask

   initial begin
      int nd, dat, nb;
      logic [31:0] cap_bcd;
      logic [7:0]  cap_mask;

      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bcd",  64'(bcd_out), 64'd0);
      chk("rst_ovf",  64'(overflow), 64'd0);
      chk("rst_mask", 64'(lead_mask), 64'h01);
      tick();
      rst = 1'b1;
      tick();

      conv("zero",  27'd0,          32'h0000_0000, 8'h01, 1'b0);
      conv("c1234", 27'd12_345_678, 32'h1234_5678, 8'hFF, 1'b0);
      conv("c4500", 27'd4_500,      32'h0000_4500, 8'h0F, 1'b0);
      conv("max",   27'd99_999_999, 32'h9999_9999, 8'hFF, 1'b0);
      conv("sat",   27'd100_000_000,32'h9999_9999, 8'hFF, 1'b1);
      conv("clr",   27'd7,          32'h0000_0007, 8'h01, 1'b0);

      // Starts at N+5 and N+28 must be dropped; the one at N+29 is taken.
      start = 1'b1; bin_in = 27'd777;
      tick();
      start = 1'b0;
      nd = 0; dat = -1; cap_bcd = '0; cap_mask = '0;
      for (int i = 0; i < 29; i++) begin
         if (done) begin nd++; if (dat < 0) dat = i; cap_bcd = bcd_out; cap_mask = lead_mask; end
         if (i == 4 || i == 27) begin start = 1'b1; bin_in = 27'd555; end
         if (i == 28)           begin start = 1'b1; bin_in = 27'd321; end
         tick();
         start = 1'b0;
      end
      chk("ign_done_count", 64'(nd), 64'd1);
      chk("ign_done_pos",   64'(dat), 64'd27);
      chk("ign_bcd",        64'(cap_bcd), 64'h0000_0777);
      chk("ign_mask",       64'(cap_mask), 64'h07);
      chk("acc_busy",       64'(busy), 64'd1);
      nb = 0;
      for (int i = 0; i < 30; i++) begin
         if (busy) nb++;
         tick();
      end
      chk("acc_busy_cycles", 64'(nb), 64'd27);
      chk("acc_bcd",         64'(bcd_out), 64'h0000_0321);
      chk("acc_mask",        64'(lead_mask), 64'h07);

      // Reset in the middle of a conversion.
      conv("pre", 27'd1_234, 32'h0000_1234, 8'h0F, 1'b0);
      start = 1'b1; bin_in = 27'd5_678;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_bcd",  64'(bcd_out), 64'd0);
      chk("abort_mask", 64'(lead_mask), 64'h01);
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) nd++;
         tick();
      end
      rst = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (done) nd++;
         tick();
      end
      chk("abort_no_done", 64'(nd), 64'd0);
      conv("post", 27'd5_678, 32'h0000_5678, 8'h0F, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/atm_bcd_converter.md
# atm_bcd_converter

- Sequential binary-to-BCD converter for the ATM datapath.
- Takes a binary amount (balance, withdrawal, entered value) and produces the 8-digit packed-BCD word on the `data_in` port of the seven-segment display driver.
- Uses shift-and-add-3 (double dabble), one bit per clock, with a start/done handshake, overflow saturation and a leading-zero mask for digit blanking.

## Interface
Parameters:
- `BIN_W`, 27, width of the binary input (2^27 > 99,999,999).
- `DIGITS`, 8, number of BCD digits; `bcd_out` width is 4*DIGITS.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin_in`  in  BIN_W  unsigned binary value; captured at the accepting edge.
- `busy`  out  1  conversion in progress (SHIFT state).
- `done`  out  1  one-cycle pulse; `bcd_out`, `overflow` and `lead_mask` are valid from this cycle on.
- `bcd_out`  out  4*DIGITS  packed BCD; digit 7 in [31:28], digit 0 in [3:0]; connects to the display `data_in`.
- `overflow`  out  1  last captured input exceeded 99,999,999.
- `lead_mask`  out  DIGITS  bit i = 1 when digit i is significant (not a leading zero); bit 0 is always 1.

## Operation
FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 → load shift register with `bin_in`, clear BCD scratch, count=0, latch ovf = (`bin_in` > 99,999,999), go to SHIFT.
  - `start`=0 → stay.
- SHIFT, each cycle:
  - Every scratch nibble ≥5 gets +3 (no carry between nibbles).
  - Then {scratch, shreg} shifts left by 1; count++.
  - After the BIN_W-th shift → DONE.
  - The final shifted scratch is written to `bcd_out` on that same edge.
- DONE:
  - `done`=1 for exactly one cycle, then → IDLE.
- Overflow: if ovf was latched, `bcd_out` is loaded with 32'h99999999 instead of the scratch result, and `overflow`=1. Otherwise `overflow`=0.
- `lead_mask` is computed from the value loaded into `bcd_out` and registered with it. Bit i = 1 if any digit j ≥ i is nonzero; bit 0 is forced to 1.
- Hold behaviour: `bcd_out`, `overflow` and `lead_mask` hold until the next DONE. The display therefore never sees intermediate values.
- `start` while in SHIFT or DONE is ignored and not queued.
- `bin_in` changes after the accepting edge have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd_out`=0, `overflow`=0, `lead_mask`=8'h01; scratch, shreg and count are cleared.
- Reset during SHIFT or DONE aborts the conversion immediately; outputs take their reset values and no `done` pulse is produced.
- Latency, with `start` sampled high at edge N:
  - `busy` is sampled high at edges N+1 … N+BIN_W.
  - `done`=1 and the new `bcd_out` are sampled at edge N+BIN_W+1 (edge N+28 for the default).
  - The earliest next accepted `start` is edge N+BIN_W+2.
- Throughput: one conversion per BIN_W+2 cycles.
- Combinational path per cycle: DIGITS parallel nibble compare/add plus a shift. No arithmetic wider than 4 bits.
- Values above 2^BIN_W−1 cannot be represented; `bin_in` is zero-extended by the caller.

## Structure
- Shared package `atm_disp_pkg`:
  - constants `BCD_DIGITS`=8, `BIN_W`=27, `BCD_MAX`=27'd99_999_999, `BCD_SAT`=32'h99999999;
  - state enum `bcd_state_t` {IDLE, SHIFT, DONE}.
- Sub-module `bcd_add3`: combinational, 4-bit in, 4-bit out, adds 3 when the input is ≥5. Instantiated DIGITS times in a generate loop.
- All remaining logic (FSM, counter, registers, mask) lives in `atm_bcd_converter`.

## Test plan
- Reset, then `start` with `bin_in`=0:
  - `busy` high 27 cycles, `done` at N+28;
  - `bcd_out`=32'h00000000, `lead_mask`=8'h01, `overflow`=0.
- `bin_in`=12,345,678 → `bcd_out`=32'h12345678, `lead_mask`=8'hFF, `done` exactly once, at N+28.
- `bin_in`=4,500 → `bcd_out`=32'h00004500, `lead_mask`=8'h0F.
- `bin_in`=99,999,999 gives 32'h99999999 with `overflow`=0. `bin_in`=100,000,000 gives 32'h99999999 with `overflow`=1.
- `start` pulsed at N+5 and N+28 with a different `bin_in` → ignored. The result equals the first value, and the second `start` at N+29 is accepted.
- Convert 1,234 to completion, then start 5,678 and assert `rst` low at N+10:
  - `busy`, `done` and `bcd_out` go to 0 asynchronously and `lead_mask` to 8'h01;
  - no `done` pulse occurs;
  - a fresh `start` after reset converts correctly.
